nasti_data_mover: RTL and testbench

- Executes one DDR-to-BRAM copy per command from the data mover controller.
- Reads DDR as an AXI4/NASTI read-only master using INCR bursts.
- Writes each returned beat to a single-port BRAM write port.
- Reports idle/busy back to the controller on the level signal done.

---
 rtl/nasti_data_mover.sv | 214 +++++++++++++++++++++
 tb/tb_nasti_data_mover.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nasti_data_mover.sv
// DDR-to-BRAM copy engine: one command per dm_en, AXI4/NASTI INCR read bursts into a BRAM write port.
// Define NASTI_DATA_MOVER_ERR_EN to add the sticky err output (bad rresp or rlast misplacement).
module nasti_data_mover #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BRAM_AW    = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   ddr_addr,
    input  logic [ADDR_WIDTH-1:0]   bram_addr,
    input  logic [ADDR_WIDTH-1:0]   length,
    input  logic                    dm_en,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic                    bram_en,
    output logic [DATA_WIDTH/8-1:0] bram_we,
    output logic [BRAM_AW-1:0]      bram_waddr,
    output logic [DATA_WIDTH-1:0]   bram_wdata
`ifdef NASTI_DATA_MOVER_ERR_EN
    ,
    output logic                    err
`endif
);
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int LB         = $clog2(BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA, S_FINISH} state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic                    arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    rready_q, rready_d;
    logic                    bram_en_q, bram_en_d;
    logic [DATA_WIDTH/8-1:0] bram_we_q, bram_we_d;
    logic [BRAM_AW-1:0]      bram_waddr_q, bram_waddr_d;
    logic [DATA_WIDTH-1:0]   bram_wdata_q, bram_wdata_d;

    // Transfer bookkeeping; only meaningful once a command has been latched.
    logic [ADDR_WIDTH-1:0]   src_q, src_d;
    logic [ADDR_WIDTH-1:0]   rem_q, rem_d;
    logic [BRAM_AW-1:0]      dst_q, dst_d;
    logic [8:0]              cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0]   dst_full;
    logic [12:0]             bnd_beats;
    logic [8:0]              burst_beats;
    logic                    last_beat;
    logic                    unused_inputs;

    assign dst_full = bram_addr >> LB;

`ifdef NASTI_DATA_MOVER_ERR_EN
    logic err_q, err_d;
    assign err           = err_q;
    assign unused_inputs = ^{m_rresp[0], dst_full[ADDR_WIDTH-1:BRAM_AW]};
`else
    assign unused_inputs = ^{m_rresp, m_rlast, dst_full[ADDR_WIDTH-1:BRAM_AW]};
`endif

    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        rready_d     = rready_q;
        bram_en_d    = 1'b0;
        bram_we_d    = '0;
        bram_waddr_d = bram_waddr_q;
        bram_wdata_d = bram_wdata_q;
        src_d        = src_q;
        rem_d        = rem_q;
        dst_d        = dst_q;
        cnt_d        = cnt_q;
        bnd_beats    = '0;
        burst_beats  = '0;
        last_beat    = (cnt_q == 9'd1);
`ifdef NASTI_DATA_MOVER_ERR_EN
        err_d        = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (dm_en) begin
                    src_d  = ddr_addr & ~BEAT_MASK;
                    rem_d  = length >> LB;
                    dst_d  = dst_full[BRAM_AW-1:0];
                    done_d = 1'b0;
`ifdef NASTI_DATA_MOVER_ERR_EN
                    err_d  = 1'b0;
`endif
                    state_d = (rem_d == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    cnt_d     = {1'b0, arlen_q} + 9'd1;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (m_rvalid && rready_q) begin
                    bram_en_d    = 1'b1;
                    bram_we_d    = '1;
                    bram_waddr_d = dst_q;
                    bram_wdata_d = m_rdata;
                    dst_d        = dst_q + 1'b1;
                    rem_d        = rem_q - 1'b1;
                    src_d        = src_q + ADDR_WIDTH'(BEAT_BYTES);
                    cnt_d        = cnt_q - 9'd1;
`ifdef NASTI_DATA_MOVER_ERR_EN
                    if (m_rresp[1] || (m_rlast != last_beat)) begin
                        err_d = 1'b1;
                    end
`endif
                    // Our own beat count ends the burst; rlast is never trusted for control.
                    if (last_beat) begin
                        rready_d = 1'b0;
                        state_d  = (rem_d == '0) ? S_FINISH : S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Size the next burst on entry to ISSUE so the AR fields are registered and held stable.
        if (state_d == S_ISSUE && state_q != S_ISSUE) begin
            bnd_beats   = (13'h1000 - {1'b0, src_d[11:0]}) >> LB;
            burst_beats = 9'(MAX_BURST);
            if (rem_d < ADDR_WIDTH'(MAX_BURST)) begin
                burst_beats = 9'(rem_d);
            end
            if ({4'b0, burst_beats} > bnd_beats) begin
                burst_beats = 9'(bnd_beats);
            end
            araddr_d  = src_d;
            arlen_d   = 8'(burst_beats - 9'd1);
            arvalid_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b1;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            rready_q     <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= '0;
            bram_waddr_q <= '0;
            bram_wdata_q <= '0;
`ifdef NASTI_DATA_MOVER_ERR_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            rready_q     <= rready_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_waddr_q <= bram_waddr_d;
            bram_wdata_q <= bram_wdata_d;
`ifdef NASTI_DATA_MOVER_ERR_EN
            err_q        <= err_d;
`endif
        end
    end

    always_ff @(posedge aclk) begin
        src_q <= src_d;
        rem_q <= rem_d;
        dst_q <= dst_d;
        cnt_q <= cnt_d;
    end

    assign done       = done_q;
    assign m_araddr   = araddr_q;
    assign m_arlen    = arlen_q;
    assign m_arsize   = 3'(LB);
    assign m_arburst  = 2'b01;
    assign m_arvalid  = arvalid_q;
    assign m_rready   = rready_q;
    assign bram_en    = bram_en_q;
    assign bram_we    = bram_we_q;
    assign bram_waddr = bram_waddr_q;
    assign bram_wdata = bram_wdata_q;

endmodule

// File: tb/tb_nasti_data_mover.sv
// Bench for nasti_data_mover: reactive AXI read slave plus AR and BRAM-write scoreboards.
module tb_nasti_data_mover;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int BAW = 16;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic [15:0] w;
        logic [63:0] d;
    } wr_t;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [AW-1:0]     ddr_addr = '0;
    logic [AW-1:0]     bram_addr = '0;
    logic [AW-1:0]     length = '0;
    logic              dm_en = 1'b0;
    logic              done;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready = 1'b0;
    logic [DW-1:0]     m_rdata = '0;
    logic [1:0]        m_rresp = '0;
    logic              m_rlast = 1'b0;
    logic              m_rvalid = 1'b0;
    logic              m_rready;
    logic              bram_en;
    logic [DW/8-1:0]   bram_we;
    logic [BAW-1:0]    bram_waddr;
    logic [DW-1:0]     bram_wdata;
`ifdef NASTI_DATA_MOVER_ERR_EN
    logic              err;
`endif

    nasti_data_mover #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_AW(BAW), .MAX_BURST(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .ddr_addr(ddr_addr), .bram_addr(bram_addr), .length(length), .dm_en(dm_en),
        .done(done),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .bram_en(bram_en), .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata)
`ifdef NASTI_DATA_MOVER_ERR_EN
        , .err(err)
`endif
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          ar_count = 0;
    int          arv_seen = 0;
    int          bram_count = 0;
    int          beat_no = 0;
    int          err_beat = -1;
    int          last_r_cyc = 0;
    int          ar_hold = 0;
    logic        gaps = 1'b0;
    logic [31:0] tag = 32'h0;

    ar_t exp_ar[$];
    wr_t exp_bram[$];
    ar_t rq[$];

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] data_of(input logic [63:0] a);
        return {a[31:0] ^ tag, ~a[31:0]};
    endfunction

    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    // AXI read slave and BRAM monitor, evaluated at the falling edge.
    initial begin
        int   r_idx = 0;
        logic ar_hs_p = 1'b0;
        logic r_hs_p = 1'b0;
        int   r_hs_cyc = 0;
        logic ar_wait_prev = 1'b0;
        logic [63:0] ar_hs_addr = '0;
        logic [7:0]  ar_hs_len = '0;
        logic [63:0] held_addr = '0;
        logic [7:0]  held_len = '0;
        ar_t  a;
        wr_t  e;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                rq.delete();
                r_idx = 0; ar_hs_p = 1'b0; r_hs_p = 1'b0; ar_wait_prev = 1'b0;
                m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
            end else begin
                if (bram_en) begin
                    bram_count++;
                    if (exp_bram.size() == 0) begin
                        check_val("bram_write_expected", 64'(exp_bram.size()), 64'd1);
                    end else begin
                        e = exp_bram.pop_front();
                        check_val("bram_waddr", 64'(bram_waddr), 64'(e.w));
                        check_val("bram_wdata", bram_wdata, e.d);
                        check_val("bram_we", 64'(bram_we), 64'hFF);
                    end
                end
                if (m_arvalid) arv_seen++;
                if (ar_hs_p) begin
                    ar_count++;
                    if (exp_ar.size() == 0) begin
                        check_val("ar_expected", 64'(exp_ar.size()), 64'd1);
                    end else begin
                        a = exp_ar.pop_front();
                        check_val("araddr", ar_hs_addr, a.addr);
                        check_val("arlen", 64'(ar_hs_len), 64'(a.len));
                    end
                    rq.push_back({ar_hs_addr, ar_hs_len});
                end
                if (r_hs_p) begin
                    last_r_cyc = r_hs_cyc;
                    beat_no++;
                    if (rq.size() > 0) begin
                        if (r_idx == int'(rq[0].len)) begin
                            void'(rq.pop_front());
                            r_idx = 0;
                        end else begin
                            r_idx++;
                        end
                    end
                end
                if (m_arvalid && ar_wait_prev) begin
                    check_val("araddr_stable", m_araddr, held_addr);
                    check_val("arlen_stable", 64'(m_arlen), 64'(held_len));
                end
                if (m_arvalid && ar_hold > 0) begin
                    m_arready = 1'b0;
                    ar_hold--;
                end else begin
                    m_arready = 1'b1;
                end
                ar_wait_prev = m_arvalid && !m_arready;
                held_addr = m_araddr;
                held_len = m_arlen;
                if (rq.size() > 0) begin
                    m_rvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                    m_rdata  = data_of(rq[0].addr + 64'(r_idx * 8));
                    m_rlast  = (r_idx == int'(rq[0].len));
                    m_rresp  = (beat_no == err_beat) ? 2'b10 : 2'b00;
                end else begin
                    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
                end
                ar_hs_p = m_arvalid && m_arready;
                ar_hs_addr = m_araddr;
                ar_hs_len = m_arlen;
                r_hs_p = m_rvalid && m_rready;
                r_hs_cyc = cyc;
            end
        end
    end

    task automatic push_exp(input logic [63:0] src, input logic [63:0] dst, input logic [63:0] len);
        for (int i = 0; i < int'(len >> 3); i++) begin
            exp_bram.push_back({16'((dst >> 3) + 64'(i)), data_of(src + 64'(i * 8))});
        end
    endtask

    task automatic run_xfer(input logic [63:0] src, input logic [63:0] dst, input logic [63:0] len,
                            output int low_cycles);
        ddr_addr = src; bram_addr = dst; length = len; dm_en = 1'b1;
        push_exp(src, dst, len);
        @(negedge aclk);
        dm_en = 1'b0;
        check_val("busy_after_start", 64'(done), 64'd0);
        low_cycles = 1;
        while (done !== 1'b1 && low_cycles < 3000) begin
            @(negedge aclk);
            if (done !== 1'b1) low_cycles++;
        end
        if (done !== 1'b1) check_val("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic check_tail(input string name, input int ar0, input int b0,
                              input int n_ar, input int n_wr);
        check_val({name, "_ar_count"}, 64'(ar_count - ar0), 64'(n_ar));
        check_val({name, "_bram_count"}, 64'(bram_count - b0), 64'(n_wr));
        check_val({name, "_queues_drained"}, 64'(exp_ar.size() + exp_bram.size()), 64'd0);
    endtask

    initial begin
        int lowc, ar0, b0, av0, lowc2;
        repeat (3) @(negedge aclk);
        check_val("rst_done", 64'(done), 64'd1);
        check_val("rst_arvalid", 64'(m_arvalid), 64'd0);
        check_val("rst_rready", 64'(m_rready), 64'd0);
        check_val("rst_bram_en", 64'(bram_en), 64'd0);
        check_val("rst_bram_we", 64'(bram_we), 64'd0);
        check_val("rst_araddr", m_araddr, 64'd0);
        check_val("rst_arlen", 64'(m_arlen), 64'd0);
        check_val("rst_bram_waddr", 64'(bram_waddr), 64'd0);
        check_val("rst_bram_wdata", bram_wdata, 64'd0);
        check_val("arsize", 64'(m_arsize), 64'd3);
        check_val("arburst", 64'(m_arburst), 64'd1);
        #2 aresetn = 1'b1;
        @(negedge aclk);

        // Single 8-beat burst
        tag = 32'h1111_0000; ar0 = ar_count; b0 = bram_count;
        exp_ar.push_back({64'h1000, 8'd7});
        run_xfer(64'h1000, 64'h40, 64'h40, lowc);
        check_val("t1_done_latency", 64'(cyc - last_r_cyc), 64'd2);
        check_tail("t1", ar0, b0, 1, 8);
`ifdef NASTI_DATA_MOVER_ERR_EN
        check_val("err_clean", 64'(err), 64'd0);
`endif

        // Two MAX_BURST bursts, started the cycle done reads 1
        tag = 32'h2222_0000; ar0 = ar_count; b0 = bram_count;
        exp_ar.push_back({64'h1000, 8'd15});
        exp_ar.push_back({64'h1080, 8'd15});
        run_xfer(64'h1000, 64'h0, 64'h100, lowc);
        check_tail("t2", ar0, b0, 2, 32);

        // 4 KB split, BRAM word index wrapping past 0xFFFF
        tag = 32'h3333_0000; ar0 = ar_count; b0 = bram_count;
        exp_ar.push_back({64'h1FE0, 8'd3});
        exp_ar.push_back({64'h2000, 8'd3});
        run_xfer(64'h1FE0, 64'h7FFF0, 64'h40, lowc);
        check_tail("t3", ar0, b0, 2, 8);

        // Zero length
        ar0 = ar_count; b0 = bram_count; av0 = arv_seen;
        run_xfer(64'h5000, 64'h80, 64'h0, lowc);
        check_val("t4_done_low_cycles", 64'(lowc), 64'd1);
        check_val("t4_arvalid_seen", 64'(arv_seen - av0), 64'd0);
        check_tail("t4", ar0, b0, 0, 0);

        // AR stall, random rvalid gaps, stray dm_en pulse while busy
        tag = 32'h4444_0000; ar0 = ar_count; b0 = bram_count;
        ar_hold = 5; gaps = 1'b1;
        exp_ar.push_back({64'h3000, 8'd15});
        fork
            run_xfer(64'h3000, 64'h100, 64'h80, lowc2);
            begin
                repeat (6) @(negedge aclk);
                ddr_addr = 64'hDEAD_0000; length = 64'h40; dm_en = 1'b1;
                @(negedge aclk);
                dm_en = 1'b0;
                repeat (6) @(negedge aclk);
                dm_en = 1'b1;
                @(negedge aclk);
                dm_en = 1'b0;
            end
        join
        gaps = 1'b0;
        repeat (3) @(negedge aclk);
        check_val("t5_idle_after", 64'(done), 64'd1);
        check_tail("t5", ar0, b0, 1, 16);

        // Reset in the middle of DATA, then a clean transfer
        tag = 32'h5555_0000;
        exp_ar.push_back({64'h4000, 8'd15});
        exp_ar.push_back({64'h4080, 8'd15});
        ddr_addr = 64'h4000; bram_addr = 64'h200; length = 64'h100; dm_en = 1'b1;
        push_exp(64'h4000, 64'h200, 64'h100);
        @(negedge aclk);
        dm_en = 1'b0;
        repeat (8) @(negedge aclk);
        check_val("t6_in_data", 64'(m_rready), 64'd1);
        #2 aresetn = 1'b0;
        #1;
        check_val("t6_rst_done", 64'(done), 64'd1);
        check_val("t6_rst_arvalid", 64'(m_arvalid), 64'd0);
        check_val("t6_rst_rready", 64'(m_rready), 64'd0);
        check_val("t6_rst_bram_en", 64'(bram_en), 64'd0);
        check_val("t6_rst_bram_we", 64'(bram_we), 64'd0);
        exp_ar.delete();
        exp_bram.delete();
        repeat (2) @(negedge aclk);
        #2 aresetn = 1'b1;
        @(negedge aclk);
        tag = 32'h6666_0000; ar0 = ar_count; b0 = bram_count;
        exp_ar.push_back({64'h1000, 8'd7});
        run_xfer(64'h1000, 64'h40, 64'h40, lowc);
        check_val("t6_done_latency", 64'(cyc - last_r_cyc), 64'd2);
        check_tail("t6", ar0, b0, 1, 8);

`ifdef NASTI_DATA_MOVER_ERR_EN
        // SLVERR on the third beat: sticky err, data still written, cleared by next command
        tag = 32'h7777_0000; ar0 = ar_count; b0 = bram_count;
        err_beat = beat_no + 2;
        exp_ar.push_back({64'h6000, 8'd7});
        run_xfer(64'h6000, 64'h0, 64'h40, lowc);
        err_beat = -1;
        check_val("err_set", 64'(err), 64'd1);
        check_tail("t7", ar0, b0, 1, 8);
        tag = 32'h8888_0000;
        exp_ar.push_back({64'h6000, 8'd7});
        run_xfer(64'h6000, 64'h0, 64'h40, lowc);
        check_val("err_cleared", 64'(err), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
